multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for tinyCPU; the issuing end of the ALU interface: drives ALUOp and operand selects, consumes Zero.
- Sequences fetch/decode/execute/memory/writeback for an RV32I subset over a shared datapath.
- Sits between the instruction register and memory handshake on one side and the ALU, register file and PC on the other.
- Keeps a retired-instruction counter.

Parameters:
- RESET_TRAP_STICKY, 1, when 1 the TRAP state holds until reset; when 0 TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- instr  in  32  instruction register contents
- Zero  in  1  ALU zero flag, combinational, same cycle
- mem_ready  in  1  memory completes current request
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- IRWrite  out  1  load instr register
- PCWrite  out  1  load PC
- pc_src  out  1  0 = ALU result, 1 = ALUOut register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
- ImmSrc  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 PC
- ALUOp  out  5  ALU operation code
- illegal  out  1  registered, set on entering TRAP
- instret  out  32  retired instruction count

Behaviour:
- Reset, checked on a clk edge with rst=1:
  - state=FETCH, instret=0, illegal=0.
  - While rst=1, all enables (mem_req, IRWrite, PCWrite, RegWrite) are forced to 0.
  - Reset aborts any memory wait.
- Outputs are a Moore decode of state. Exceptions: ALUOp in EXEC_R/EXEC_I comes from the instr fields, and PCWrite in BRANCH depends on Zero.
- Unlisted outputs are 0 in each state. ALUOp default is ADD=5'b00011.
- FETCH:
  - mem_req=1, mem_we=0, ALUSrcA=PC, ALUSrcB=4, ADD.
  - Stays in FETCH until mem_ready. On mem_ready: IRWrite=1, PCWrite=1, pc_src=0, then go to DECODE.
- DECODE:
  - ALUSrcA=oldPC, ALUSrcB=imm, ImmSrc=B for a branch, J for JAL; ADD. The result is latched to ALUOut by the datapath.
  - Dispatch on opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011, 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - anything else -> TRAP
- EXEC_R: rs1 op rs2 -> ALU_WB.
  - ALUOp by {funct7[5],funct3}: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU.
  - Any other funct7 -> TRAP.
- EXEC_I: rs1 op immI, same mapping.
  - funct7[5] is honoured only for funct3=101 (SRAI).
  - SUB is never produced.
- ALU_WB: RegWrite=1, ResultSrc=ALUOut -> FETCH, retire.
- MEM_ADDR: rs1+imm (ImmSrc I for load, S for store) -> MEM_RD or MEM_WR.
- MEM_RD: mem_req=1, waits on mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, ResultSrc=mem data -> FETCH, retire.
- MEM_WR: mem_req=1, mem_we=1, waits on mem_ready -> FETCH, retire.
- BRANCH:
  - rs1-rs2 with SUB.
  - PCWrite = (funct3=000 & Zero) | (funct3=001 & !Zero), with pc_src=1.
  - Other funct3 -> TRAP. Otherwise -> FETCH, retire.
- JAL: PCWrite=1, pc_src=1, RegWrite=1, ResultSrc=PC (pre-update PC, already +4) -> FETCH, retire.
- LUI: ALUSrcA=zero, ALUSrcB=imm, ImmSrc=U, ADD -> ALU_WB.
- TRAP: illegal<=1, no enables. Holds or returns per RESET_TRAP_STICKY.
- mem_req stays asserted unchanged until mem_ready. A mem_ready seen outside a wait state is ignored.
- instret increments by 1 on each retire edge and wraps from 0xFFFFFFFF to 0.
- Minimum latencies with mem_ready immediate: R/I/LUI 4, LW 5, SW 4, BEQ/BNE 3, JAL 3.

Decomposition:
- Package alu_pkg holds:
  - ALUOp constants: ADD 00011, SUB 00100, AND 00101, OR 00110, XOR 00111, SLL 01000, SRL 01001, SRA 01010, SLT 01011, SLTU 01100.
  - Opcode constants.
  - State enum.
  - Select encodings.
- Sub-module alu_decoder: combinational {opcode class, funct3, funct7} -> ALUOp plus a legal flag.

Test Plan:
- Reset mid-MEM_RD with mem_ready low -> next cycle FETCH, instret=0, no enables asserted during reset.
- add x3,x1,x2 then sub x4,x1,x2 -> ALUOp 00011 and 00100 in EXEC_R; 4 cycles each; instret=2.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held steady; retires on cycle 11; RegWrite only in MEM_WB.
- beq with Zero=1 -> PCWrite=1, pc_src=1; bne with Zero=1 -> PCWrite=0; each retires in 3 cycles.
- Opcode 0x7F -> TRAP, illegal=1, held 10 cycles; instret unchanged.
- Preload instret to 0xFFFFFFFF via back-to-back JALs -> wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the tinyCPU multi-cycle control path: ALU ops, opcodes,
// FSM states and datapath select values.
package alu_pkg;

    localparam logic [4:0] AluAdd  = 5'b00011;
    localparam logic [4:0] AluSub  = 5'b00100;
    localparam logic [4:0] AluAnd  = 5'b00101;
    localparam logic [4:0] AluOr   = 5'b00110;
    localparam logic [4:0] AluXor  = 5'b00111;
    localparam logic [4:0] AluSll  = 5'b01000;
    localparam logic [4:0] AluSrl  = 5'b01001;
    localparam logic [4:0] AluSra  = 5'b01010;
    localparam logic [4:0] AluSlt  = 5'b01011;
    localparam logic [4:0] AluSltu = 5'b01100;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmJ = 3'd3;
    localparam logic [2:0] ImmU = 3'd4;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResPc     = 2'b11;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAddr, StMemRd,
        StMemWb, StMemWr, StBranch, StJal, StLui, StTrap
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 of an OP or OP-IMM instruction to an ALU operation and
// flags encodings that have no ALU operation.
module alu_decoder
    import alu_pkg::*;
(
    input  logic       is_imm_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [4:0] aluop_o,
    output logic       legal_o
);

    logic alt;

    always_comb begin
        legal_o = 1'b1;
        aluop_o = AluAdd;
        // Immediate forms carry shamt in funct7, so only SRAI looks at bit 5.
        alt = is_imm_i ? (funct3_i == 3'b101) && funct7_i[5] : funct7_i[5];
        if (!is_imm_i && (funct7_i != 7'b0000000) && (funct7_i != 7'b0100000)) begin
            legal_o = 1'b0;
        end
        case ({alt, funct3_i})
            4'b0000: aluop_o = AluAdd;
            4'b1000: aluop_o = AluSub;
            4'b0111: aluop_o = AluAnd;
            4'b0110: aluop_o = AluOr;
            4'b0100: aluop_o = AluXor;
            4'b0001: aluop_o = AluSll;
            4'b0101: aluop_o = AluSrl;
            4'b1101: aluop_o = AluSra;
            4'b0010: aluop_o = AluSlt;
            4'b0011: aluop_o = AluSltu;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller for tinyCPU,
// with a retired-instruction counter and a sticky illegal-instruction flag.
module multicycle_ctrl
    import alu_pkg::*;
#(
    parameter bit RESET_TRAP_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        pc_src,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [4:0]  ALUOp,
    output logic        illegal,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] instret_q;
    logic        illegal_q;
    logic        retire;
    logic [4:0]  dec_aluop;
    logic        dec_legal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    alu_decoder u_alu_decoder (
        .is_imm_i (state_q == StExecI),
        .funct3_i (funct3),
        .funct7_i (instr[31:25]),
        .aluop_o  (dec_aluop),
        .legal_o  (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        pc_src    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        ImmSrc    = ImmI;
        ResultSrc = ResAluOut;
        ALUOp     = AluAdd;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                ALUSrcA = SrcAPc;
                ALUSrcB = SrcBFour;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Branch/jump target computed here and parked in ALUOut.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                if (opcode == OpcBranch) ImmSrc = ImmB;
                else if (opcode == OpcJal) ImmSrc = ImmJ;
                case (opcode)
                    OpcOp:             state_d = StExecR;
                    OpcOpImm:          state_d = StExecI;
                    OpcLoad, OpcStore: state_d = StMemAddr;
                    OpcBranch:         state_d = StBranch;
                    OpcJal:            state_d = StJal;
                    OpcLui:            state_d = StLui;
                    default:           state_d = StTrap;
                endcase
            end
            StExecR, StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = (state_q == StExecI) ? SrcBImm : SrcBRs2;
                ALUOp   = dec_aluop;
                state_d = dec_legal ? StAluWb : StTrap;
            end
            StAluWb: begin
                RegWrite  = 1'b1;
                ResultSrc = ResAluOut;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemAddr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ImmSrc  = (opcode == OpcStore) ? ImmS : ImmI;
                state_d = (opcode == OpcStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite  = 1'b1;
                ResultSrc = ResMem;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StBranch: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBRs2;
                ALUOp   = AluSub;
                pc_src  = 1'b1;
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    PCWrite = (funct3 == 3'b000) ? Zero : !Zero;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StTrap;
                end
            end
            StJal: begin
                PCWrite   = 1'b1;
                pc_src    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = ResPc;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StLui: begin
                ALUSrcA = SrcAZero;
                ALUSrcB = SrcBImm;
                ImmSrc  = ImmU;
                state_d = StAluWb;
            end
            StTrap: begin
                if (!RESET_TRAP_STICKY) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + 32'd1;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

    assign instret = instret_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps instructions cycle by cycle and
// checks control outputs against hand-computed values.
module tb_multicycle_ctrl;

    localparam logic [31:0] IAdd  = 32'h002081B3;
    localparam logic [31:0] ISub  = 32'h40208233;
    localparam logic [31:0] IXor  = 32'h0020C1B3;
    localparam logic [31:0] ISrai = 32'h4050D093;
    localparam logic [31:0] ILui  = 32'h123452B7;
    localparam logic [31:0] ILw   = 32'h0000A283;
    localparam logic [31:0] ISw   = 32'h0020A023;
    localparam logic [31:0] IBeq  = 32'h00208063;
    localparam logic [31:0] IBne  = 32'h00209063;
    localparam logic [31:0] IJal  = 32'h000000EF;
    localparam logic [31:0] IBad  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst, Zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, IRWrite, PCWrite, pc_src, RegWrite, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [4:0]  ALUOp;
    logic [31:0] instret;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .pc_src    (pc_src),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .instret   (instret)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_jal;
        instr = IJal; mem_ready = 1'b1;
        tick; mem_ready = 1'b0; #1;
        n_cmp++;
        if (ImmSrc !== 3'd3) begin
            n_fail++; $display("FAIL jal_decode_imm: got %0d want 3", ImmSrc);
        end
        tick; #1;
        n_cmp++;
        if ({PCWrite, pc_src, RegWrite, ResultSrc} !== 5'b11111) begin
            n_fail++;
            $display("FAIL jal_ctrl: got %b want 11111", {PCWrite, pc_src, RegWrite, ResultSrc});
        end
        tick; exp_ret = exp_ret + 32'd1; #1;
        n_cmp++;
        if (instret !== exp_ret) begin
            n_fail++; $display("FAIL jal_instret: got %h want %h", instret, exp_ret);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; instr = 32'd0; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({mem_req, IRWrite, PCWrite, RegWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_enables: got %b want 0000", {mem_req, IRWrite, PCWrite, RegWrite});
        end
        tick;
        n_cmp++;
        if ({illegal, instret} !== 33'd0) begin
            n_fail++; $display("FAIL reset_regs: got %b/%h want 0/0", illegal, instret);
        end
        rst = 1'b0; mem_ready = 1'b0; exp_ret = 32'd0; #1;
        n_cmp++;
        if ({mem_req, IRWrite, ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 1'b0, 2'b00, 2'b10, 5'b00011}) begin
            n_fail++;
            $display("FAIL reset_fetch: got %b want 100010" , {mem_req, IRWrite, ALUSrcA, ALUSrcB});
        end
    endtask

    task automatic test_reset_mid_memrd;
        run_jal;
        instr = ILw; mem_ready = 1'b1;
        tick; mem_ready = 1'b0;
        tick; tick; #1;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL memrd_req: got %b want 1", mem_req);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({mem_req, IRWrite, PCWrite, RegWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_enables: got %b want 0000", {mem_req, IRWrite, PCWrite, RegWrite});
        end
        tick; rst = 1'b0; exp_ret = 32'd0; #1;
        n_cmp++;
        if ({instret, mem_req, ALUSrcB} !== {32'd0, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL midrst_fetch: got %h/%b/%b want 0/1/10", instret, mem_req, ALUSrcB);
        end
    endtask

    task automatic run_alu(input logic [31:0] ins, input logic [4:0] op,
                           input logic [1:0] srca, input logic [1:0] srcb);
        instr = ins; mem_ready = 1'b1; #1;
        n_cmp++;
        if ({IRWrite, PCWrite, pc_src} !== 3'b110) begin
            n_fail++; $display("FAIL alu_fetch: got %b want 110", {IRWrite, PCWrite, pc_src});
        end
        tick; mem_ready = 1'b0; #1;
        n_cmp++;
        if ({ALUSrcA, ALUSrcB} !== 4'b0101) begin
            n_fail++; $display("FAIL alu_decode: got %b want 0101", {ALUSrcA, ALUSrcB});
        end
        tick; #1;
        n_cmp++;
        if ({ALUOp, ALUSrcA, ALUSrcB, RegWrite} !== {op, srca, srcb, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_exec %h: got %b want %b", ins, {ALUOp, ALUSrcA, ALUSrcB, RegWrite},
                     {op, srca, srcb, 1'b0});
        end
        tick; #1;
        n_cmp++;
        if ({RegWrite, ResultSrc, instret} !== {1'b1, 2'b00, exp_ret}) begin
            n_fail++;
            $display("FAIL alu_wb: got %b/%b/%h want 1/00/%h", RegWrite, ResultSrc, instret, exp_ret);
        end
        tick; exp_ret = exp_ret + 32'd1; #1;
        n_cmp++;
        if ({instret, mem_req} !== {exp_ret, 1'b1}) begin
            n_fail++; $display("FAIL alu_retire: got %h/%b want %h/1", instret, mem_req, exp_ret);
        end
    endtask

    task automatic test_alu_ops;
        run_alu(IAdd, 5'b00011, 2'b10, 2'b00);
        run_alu(ISub, 5'b00100, 2'b10, 2'b00);
        n_cmp++;
        if (instret !== 32'd2) begin
            n_fail++; $display("FAIL add_sub_count: got %h want 2", instret);
        end
        run_alu(IXor, 5'b00111, 2'b10, 2'b00);
        run_alu(ISrai, 5'b01010, 2'b10, 2'b01);
        run_alu(ILui, 5'b00011, 2'b11, 2'b01);
    endtask

    task automatic test_lw_delayed;
        instr = ILw; mem_ready = 1'b0;
        repeat (3) begin
            #1;
            n_cmp++;
            if ({mem_req, mem_we, IRWrite, ALUSrcA} !== 5'b10000) begin
                n_fail++; $display("FAIL lw_fetch_wait: got %b want 10000", {mem_req, mem_we, IRWrite, ALUSrcA});
            end
            tick;
        end
        mem_ready = 1'b1; #1;
        n_cmp++;
        if ({mem_req, IRWrite} !== 2'b11) begin
            n_fail++; $display("FAIL lw_fetch_done: got %b want 11", {mem_req, IRWrite});
        end
        tick; tick; #1;
        n_cmp++;
        if ({ALUSrcA, ALUSrcB, ImmSrc, mem_req} !== {2'b10, 2'b01, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL lw_addr: got %b want 10010000", {ALUSrcA, ALUSrcB, ImmSrc, mem_req});
        end
        mem_ready = 1'b0;
        tick;
        repeat (3) begin
            #1;
            n_cmp++;
            if ({mem_req, mem_we, RegWrite} !== 3'b100) begin
                n_fail++; $display("FAIL lw_memrd_wait: got %b want 100", {mem_req, mem_we, RegWrite});
            end
            tick;
        end
        mem_ready = 1'b1;
        tick; mem_ready = 1'b0; #1;
        n_cmp++;
        if ({RegWrite, ResultSrc, mem_req, instret} !== {1'b1, 2'b01, 1'b0, exp_ret}) begin
            n_fail++;
            $display("FAIL lw_memwb: got %b/%b/%b/%h want 1/01/0/%h", RegWrite, ResultSrc, mem_req,
                     instret, exp_ret);
        end
        tick; exp_ret = exp_ret + 32'd1; #1;
        n_cmp++;
        if (instret !== exp_ret) begin
            n_fail++; $display("FAIL lw_retire_cycle11: got %h want %h", instret, exp_ret);
        end
    endtask

    task automatic test_sw;
        instr = ISw; mem_ready = 1'b1;
        tick; tick; #1;
        n_cmp++;
        if (ImmSrc !== 3'd1) begin
            n_fail++; $display("FAIL sw_imm: got %0d want 1", ImmSrc);
        end
        tick; #1;
        n_cmp++;
        if ({mem_req, mem_we, RegWrite} !== 3'b110) begin
            n_fail++; $display("FAIL sw_memwr: got %b want 110", {mem_req, mem_we, RegWrite});
        end
        tick; mem_ready = 1'b0; exp_ret = exp_ret + 32'd1; #1;
        n_cmp++;
        if (instret !== exp_ret) begin
            n_fail++; $display("FAIL sw_retire: got %h want %h", instret, exp_ret);
        end
    endtask

    task automatic run_branch(input logic [31:0] ins, input logic z, input logic pcw);
        instr = ins; mem_ready = 1'b1;
        tick; mem_ready = 1'b0; #1;
        n_cmp++;
        if (ImmSrc !== 3'd2) begin
            n_fail++; $display("FAIL br_decode_imm: got %0d want 2", ImmSrc);
        end
        tick; Zero = z; #1;
        n_cmp++;
        if ({PCWrite, pc_src, ALUOp, RegWrite} !== {pcw, 1'b1, 5'b00100, 1'b0}) begin
            n_fail++;
            $display("FAIL br_exec %h z=%b: got %b want %b", ins, z, {PCWrite, pc_src, ALUOp, RegWrite},
                     {pcw, 1'b1, 5'b00100, 1'b0});
        end
        tick; Zero = 1'b0; exp_ret = exp_ret + 32'd1; #1;
        n_cmp++;
        if ({instret, mem_req} !== {exp_ret, 1'b1}) begin
            n_fail++; $display("FAIL br_retire: got %h/%b want %h/1", instret, mem_req, exp_ret);
        end
    endtask

    task automatic test_branch;
        run_branch(IBeq, 1'b1, 1'b1);
        run_branch(IBne, 1'b1, 1'b0);
        run_branch(IBne, 1'b0, 1'b1);
        run_branch(IBeq, 1'b0, 1'b0);
    endtask

    task automatic test_trap;
        instr = IBad; mem_ready = 1'b1;
        tick; mem_ready = 1'b0; #1;
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_fail++; $display("FAIL trap_early: got %b want 0", illegal);
        end
        tick;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if ({illegal, mem_req, IRWrite, PCWrite, RegWrite, instret} !== {5'b10000, exp_ret}) begin
                n_fail++;
                $display("FAIL trap_hold[%0d]: got %b/%h want 10000/%h", i,
                         {illegal, mem_req, IRWrite, PCWrite, RegWrite}, instret, exp_ret);
            end
            tick;
        end
        mem_ready = 1'b0; rst = 1'b1;
        tick; rst = 1'b0; exp_ret = 32'd0; #1;
        n_cmp++;
        if ({illegal, mem_req} !== 2'b01) begin
            n_fail++; $display("FAIL trap_reset: got %b want 01", {illegal, mem_req});
        end
    endtask

    task automatic test_back_to_back_wrap;
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_ret = 32'hFFFF_FFFE;
        run_jal;
        run_jal;
        n_cmp++;
        if (instret !== 32'd0) begin
            n_fail++; $display("FAIL wrap_zero: got %h want 0", instret);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_reset_mid_memrd;
        test_alu_ops;
        test_lw_delayed;
        test_sw;
        test_branch;
        test_trap;
        test_back_to_back_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
